rank_classifier: RTL
====================

Name: rank_classifier

Overview:
- Consumes the per-rank XOR mismatch scores produced by the thirteen rank template matchers (A..K), one matcher per rank.
- Collects one score per rank for the current card corner, then sequentially scans them.
- Reports the rank with the lowest mismatch, plus best and runner-up scores for the downstream card-decision logic.

Parameters:
- NUM_RANKS, 13, number of rank matchers; index 0=A, 1=2 … 9=10, 10=J, 11=Q, 12=K.
- SCORE_W, 11, score width; equals $clog2(corner_width*rank_height) = $clog2(1120).
- MIN_MARGIN, 32, minimum runner_up_score - best_score for confident=1 (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse; discards any partial collection and starts a new one
- score_in  in  NUM_RANKS*SCORE_W  packed scores; slice i = [i*SCORE_W +: SCORE_W]
- score_valid  in  NUM_RANKS  bit i pulses for one cycle when slice i holds a final score
- busy  out  1  high in SCAN
- rank_out  out  4  winning rank, index+1 (1..13)
- best_score  out  SCORE_W  lowest score
- runner_up_score  out  SCORE_W  second-lowest score; may equal best_score
- result_valid  out  1  one-cycle pulse when outputs update
- confident  out  1  margin flag

Behaviour:
- Reset: the following all clear to 0: rank_out, best_score, runner_up_score, result_valid, busy, confident, the got[] flags, and the scan index. State becomes COLLECT. rst overrides all other inputs, including mid-SCAN; no result_valid is produced for an aborted scan.
- States are COLLECT and SCAN.
- COLLECT:
  - For each i with score_valid[i]=1, latch slice i into store[i] and set got[i].
  - A repeated strobe for an already-got rank overwrites store[i] (last value wins).
  - When got becomes all-ones, including on the same edge as the final latch, go to SCAN next cycle.
  - Initialise scan registers: idx=0, best=all-ones, runner=all-ones, best_idx=0.
- SCAN (busy=1): one entry per clock, idx 0..NUM_RANKS-1. Comparison rule for entry s=store[idx]:
  - if s < best: runner=best, best=s, best_idx=idx
  - else if s < runner: runner=s
  - Comparisons are unsigned and strict, so on a tie the lowest index wins.
- Completion: on the edge that processes idx=NUM_RANKS-1:
  - Register rank_out, best_score and runner_up_score from the final values, including that last entry.
  - Register confident and set result_valid=1.
  - Clear got[] and return to COLLECT.
- result_valid is high for exactly one cycle. Outputs hold until the next result or rst.
- Latency: result_valid is high in the cycle following the NUM_RANKS-th edge after the edge that sampled the final strobe. With NUM_RANKS=13, that is 13 edges.
- score_valid during SCAN is ignored and dropped; it is not latched for the next frame.
- frame_start:
  - In any state, clear got[] and force COLLECT; an in-progress scan is aborted with no result_valid.
  - Previously reported outputs are unchanged.
  - If frame_start and score_valid[i] arrive on the same edge, the clear applies first and then store[i]/got[i] are latched for the new frame.
- Outputs never wrap. A score of all-ones still participates: if every score is all-ones, rank_out=1.

Optional Feature:
- RANK_CLASSIFIER_MARGIN_EN defined: confident = ((runner_up - best) >= MIN_MARGIN), computed at completion with unsigned SCORE_W arithmetic. The subtraction is never negative because runner >= best.
- Undefined: confident is driven 1 whenever result_valid fires and holds 1 until rst. MIN_MARGIN is unused.

Test Plan:
- All 13 strobes in one cycle; scores 500 except idx 9=37 -> 13 edges later result_valid pulses once; rank_out=10, best=37, runner=500, busy high for 13 cycles.
- Tie: idx 3 and idx 7 both 12, others 800 -> rank_out=4, best=12, runner=12.
- Staggered strobes, one per cycle; idx 0 strobed with 5, then again with 900; all others 300 -> rank_out=2, best=300, runner=300 (duplicate overwrite verified).
- 6 strobes, then frame_start, then 13 fresh strobes with idx 12=20 -> exactly one result_valid, rank_out=13; additionally, strobes sent during SCAN leave the following frame incomplete (no result until all 13 re-arrive).
- rst asserted at scan idx=5 -> all outputs 0 on the next cycle, no result_valid; a subsequent full frame classifies normally.
- MARGIN_EN, MIN_MARGIN=50: best 100 / runner 140 -> confident=0; best 100 / runner 160 -> confident=1. Without the macro, both cases -> confident=1.

Source files
------------

// File: rtl/rank_classifier.sv
// Collects one mismatch score per rank, then scans them one per clock to find the best and runner-up.
// Result pulses NUM_RANKS edges after the final score lands; no backpressure. RANK_CLASSIFIER_MARGIN_EN enables the margin flag.
module rank_classifier #(
  parameter int NUM_RANKS  = 13,
  parameter int SCORE_W    = 11,
  parameter int MIN_MARGIN = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [NUM_RANKS*SCORE_W-1:0] score_in,
  input  logic [NUM_RANKS-1:0]         score_valid,
  output logic                         busy,
  output logic [3:0]                   rank_out,
  output logic [SCORE_W-1:0]           best_score,
  output logic [SCORE_W-1:0]           runner_up_score,
  output logic                         result_valid,
  output logic                         confident
);

  localparam int IDX_W = $clog2(NUM_RANKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RANKS - 1);
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_SCAN    = 1'b1;

`ifdef RANK_CLASSIFIER_MARGIN_EN
  localparam bit MARGIN_EN = 1'b1;
`else
  localparam bit MARGIN_EN = 1'b0;
`endif
  localparam logic [SCORE_W-1:0] MARGIN_THR = SCORE_W'(MIN_MARGIN);

  logic [0:0]           state_q, state_d;
  logic [NUM_RANKS-1:0] got_q, got_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [SCORE_W-1:0]   runner_q, runner_d;
  logic [IDX_W-1:0]     best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]   store_q [NUM_RANKS];
  logic [SCORE_W-1:0]   store_d [NUM_RANKS];

  logic [3:0]           rank_out_q, rank_out_d;
  logic [SCORE_W-1:0]   best_score_q, best_score_d;
  logic [SCORE_W-1:0]   runner_up_q, runner_up_d;
  logic                 result_valid_q, result_valid_d;
  logic                 confident_q, confident_d;

  logic [SCORE_W-1:0]   scan_s;
  logic [SCORE_W-1:0]   best_nx, runner_nx, margin;
  logic [IDX_W-1:0]     best_idx_nx;
  logic [NUM_RANKS-1:0] got_base;

  // Running min / second-min update for the entry under the scan pointer.
  always_comb begin
    scan_s      = store_q[idx_q];
    best_nx     = best_q;
    runner_nx   = runner_q;
    best_idx_nx = best_idx_q;
    if (scan_s < best_q) begin
      runner_nx   = best_q;
      best_nx     = scan_s;
      best_idx_nx = idx_q;
    end else if (scan_s < runner_q) begin
      runner_nx = scan_s;
    end
    margin = runner_nx - best_nx;
  end

  always_comb begin
    state_d        = state_q;
    got_d          = got_q;
    idx_d          = idx_q;
    best_d         = best_q;
    runner_d       = runner_q;
    best_idx_d     = best_idx_q;
    store_d        = store_q;
    rank_out_d     = rank_out_q;
    best_score_d   = best_score_q;
    runner_up_d    = runner_up_q;
    confident_d    = confident_q;
    result_valid_d = 1'b0;
    got_base       = '0;

    if (state_q == ST_SCAN && !frame_start) begin
      idx_d      = idx_q + 1'b1;
      best_d     = best_nx;
      runner_d   = runner_nx;
      best_idx_d = best_idx_nx;
      if (idx_q == LAST_IDX) begin
        rank_out_d     = 4'(best_idx_nx) + 4'd1;
        best_score_d   = best_nx;
        runner_up_d    = runner_nx;
        confident_d    = !MARGIN_EN || (margin >= MARGIN_THR);
        result_valid_d = 1'b1;
        got_d          = '0;
        state_d        = ST_COLLECT;
      end
    end else begin
      // frame_start clears first so same-edge strobes belong to the new frame.
      got_base = frame_start ? '0 : got_q;
      for (int i = 0; i < NUM_RANKS; i++) begin
        if (score_valid[i]) begin
          store_d[i]  = score_in[i*SCORE_W +: SCORE_W];
          got_base[i] = 1'b1;
        end
      end
      got_d      = got_base;
      state_d    = (&got_base) ? ST_SCAN : ST_COLLECT;
      idx_d      = '0;
      best_d     = '1;
      runner_d   = '1;
      best_idx_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_COLLECT;
      got_q          <= '0;
      idx_q          <= '0;
      best_q         <= '0;
      runner_q       <= '0;
      best_idx_q     <= '0;
      rank_out_q     <= '0;
      best_score_q   <= '0;
      runner_up_q    <= '0;
      result_valid_q <= 1'b0;
      confident_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      got_q          <= got_d;
      idx_q          <= idx_d;
      best_q         <= best_d;
      runner_q       <= runner_d;
      best_idx_q     <= best_idx_d;
      rank_out_q     <= rank_out_d;
      best_score_q   <= best_score_d;
      runner_up_q    <= runner_up_d;
      result_valid_q <= result_valid_d;
      confident_q    <= confident_d;
    end
  end

  always_ff @(posedge clk) begin
    store_q <= store_d;
  end

  assign busy            = (state_q == ST_SCAN);
  assign rank_out        = rank_out_q;
  assign best_score      = best_score_q;
  assign runner_up_score = runner_up_q;
  assign result_valid    = result_valid_q;
  assign confident       = confident_q;

endmodule
